// File: rtl/night_pkg.sv
// Shared lamp encodings, FSM state type and lamp decode for the night controller.
package night_pkg;

    localparam logic [1:0] LAMP_DARK = 2'b00;
    localparam logic [1:0] LAMP_RED  = 2'b01;
    localparam logic [1:0] LAMP_YEL  = 2'b10;
    localparam logic [1:0] LAMP_GRN  = 2'b11;

    typedef enum logic [2:0] {
        StFlash   = 3'd0,
        StMainYel = 3'd1,
        StSideGrn = 3'd2,
        StSideYel = 3'd3,
        StAllRed  = 3'd4,
        StHold    = 3'd5
    } state_t;

    // Lamp code for one approach given the controller state and flash phase.
    function automatic logic [1:0] lamp_code(state_t st, logic phase_on, logic is_main);
        logic [1:0] code;
        case (st)
            StFlash:   code = phase_on ? (is_main ? LAMP_YEL : LAMP_RED) : LAMP_DARK;
            StMainYel: code = is_main ? LAMP_YEL : LAMP_RED;
            StSideGrn: code = is_main ? LAMP_RED : LAMP_GRN;
            StSideYel: code = is_main ? LAMP_RED : LAMP_YEL;
            default:   code = LAMP_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/night_flash_ctrl_flash_gen.sv
// Flash half-period counter and on/off phase, with enable and synchronous clear.
module flash_gen #(
    parameter int unsigned FLASH_HALF = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap,
    output logic phase_next
);
    localparam int unsigned CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign wrap       = (cnt_q == CW'(FLASH_HALF - 1));
    assign phase_next = phase_d;

    // Clear wins over count; phase toggles on each half-period wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (en) begin
            if (wrap) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and phase registers; reset starts in the on-phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/night_flash_ctrl.sv
// Night-mode intersection controller: flashing idle plus demand-driven side-road serve.
module night_flash_ctrl
    import night_pkg::*;
#(
    parameter int unsigned       NUM_DIR    = 4,
    parameter logic [NUM_DIR-1:0] MAIN_MASK = 4'b0101,
    parameter int unsigned       FLASH_HALF = 8,
    parameter int unsigned       YEL_CYC    = 4,
    parameter int unsigned       GREEN_CYC  = 16,
    parameter int unsigned       ALLRED_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 night_en,
    input  logic [NUM_DIR-1:0]   side_req,
    output logic [2*NUM_DIR-1:0] lane_out,
    output logic                 serving
);
    localparam int unsigned MAX_YG  = (YEL_CYC > GREEN_CYC) ? YEL_CYC : GREEN_CYC;
    localparam int unsigned MAX_CYC = (MAX_YG > ALLRED_CYC) ? MAX_YG : ALLRED_CYC;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          serving_q;
    logic [1:0]    lamp_q [NUM_DIR];
    logic          cyc_last;
    logic          side_seen;
    logic          flash_wrap;
    logic          phase_next;

    assign side_seen = |(side_req & ~MAIN_MASK);

    flash_gen #(
        .FLASH_HALF(FLASH_HALF)
    ) u_flash_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == StFlash),
        .clr       (state_d != StFlash),
        .wrap      (flash_wrap),
        .phase_next(phase_next)
    );

    // Last cycle of the current timed state.
    always_comb begin
        cyc_last = 1'b0;
        case (state_q)
            StMainYel: cyc_last = (timer_q == TW'(YEL_CYC - 1));
            StSideGrn: cyc_last = (timer_q == TW'(GREEN_CYC - 1));
            StSideYel: cyc_last = (timer_q == TW'(YEL_CYC - 1));
            StAllRed:  cyc_last = (timer_q == TW'(ALLRED_CYC - 1));
            default:   cyc_last = 1'b0;
        endcase
    end

    // Next state, timer and pending demand.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        case (state_q)
            StFlash: begin
                if (!night_en)                    state_d = StHold;
                else if (pending_q && flash_wrap) state_d = StMainYel;
            end
            StMainYel: begin
                if (!night_en)     state_d = StHold;
                else if (cyc_last) state_d = StSideGrn;
            end
            // Losing night mode in green still goes through a full yellow.
            StSideGrn: begin
                if (!night_en || cyc_last) state_d = StSideYel;
            end
            StSideYel: begin
                if (cyc_last) state_d = night_en ? StAllRed : StHold;
            end
            StAllRed: begin
                if (!night_en)     state_d = StHold;
                else if (cyc_last) state_d = StFlash;
            end
            StHold: begin
                if (night_en) state_d = StAllRed;
            end
            default: state_d = StFlash;
        endcase

        if (state_d != state_q || state_q == StFlash || state_q == StHold) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Demand is latched outside green; green entry and HOLD consume it.
        if (state_q == StHold || (state_d == StSideGrn && state_q != StSideGrn)) begin
            pending_d = 1'b0;
        end else if (state_q != StSideGrn && side_seen) begin
            pending_d = 1'b1;
        end
    end

    // FSM, timer, pending and serving registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFlash;
            timer_q   <= '0;
            pending_q <= 1'b0;
            serving_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            serving_q <= (state_d != StFlash);
        end
    end

    assign serving = serving_q;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
        localparam logic IS_MAIN = MAIN_MASK[i];

        // Registered lamp per approach, decoded from next state so it tracks state_q.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) lamp_q[i] <= lamp_code(StFlash, 1'b1, IS_MAIN);
            else     lamp_q[i] <= lamp_code(state_d, phase_next, IS_MAIN);
        end

        assign lane_out[2*i +: 2] = lamp_q[i];
    end

endmodule

// File: tb/tb_night_flash_ctrl.sv
// Scoreboard bench for night_flash_ctrl with directed, hand-computed vectors.
module tb_night_flash_ctrl;

    localparam logic [7:0] L_ON  = 8'b01100110;
    localparam logic [7:0] L_OFF = 8'h00;
    localparam logic [7:0] L_GRN = 8'b11011101;
    localparam logic [7:0] L_SY  = 8'b10011001;
    localparam logic [7:0] L_AR  = 8'h55;

    logic       clk = 1'b0;
    logic       rst;
    logic       night_en;
    logic [3:0] side_req;
    logic [7:0] lane_out;
    logic       serving;

    typedef struct {
        logic [7:0] lane;
        logic       serv;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    vec_cnt  = 0;
    int    miss_cnt = 0;
    string cur_tag  = "init";

    always #5 clk = ~clk;

    night_flash_ctrl #(
        .NUM_DIR   (4),
        .MAIN_MASK (4'b0101),
        .FLASH_HALF(4),
        .YEL_CYC   (3),
        .GREEN_CYC (5),
        .ALLRED_CYC(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .night_en(night_en),
        .side_req(side_req),
        .lane_out(lane_out),
        .serving (serving)
    );

    // Drive one cycle of inputs and queue the output expected after the next edge.
    task automatic cyc(input logic ne, input logic [3:0] req, input logic [7:0] lane,
                       input logic serv);
        exp_t e;
        night_en = ne;
        side_req = req;
        e.lane   = lane;
        e.serv   = serv;
        e.tag    = cur_tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic rep(input int n, input logic ne, input logic [3:0] req,
                       input logic [7:0] lane, input logic serv);
        for (int k = 0; k < n; k++) cyc(ne, req, lane, serv);
    endtask

    // Monitor: one expected entry per rising edge, checked just after it.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vec_cnt++;
            if (lane_out !== e.lane || serving !== e.serv) begin
                miss_cnt++;
                $display("FAIL %s (vec %0d): lane_out=%b serving=%b, expected lane_out=%b serving=%b",
                         e.tag, vec_cnt, lane_out, serving, e.lane, e.serv);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        night_en = 1'b1;
        side_req = 4'b0000;

        cur_tag = "reset";
        rep(2, 1'b1, 4'b0000, L_ON, 1'b0);
        rst = 1'b0;

        cur_tag = "idle_flash";
        rep(3, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0000, L_OFF, 1'b0);
        rep(4, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0000, L_OFF, 1'b0);

        cur_tag = "serve_pulse";
        cyc(1'b1, 4'b0000, L_ON, 1'b0);
        cyc(1'b1, 4'b0010, L_ON, 1'b0);
        rep(2, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b1);
        rep(5, 1'b1, 4'b0000, L_GRN, 1'b1);
        rep(3, 1'b1, 4'b0000, L_SY,  1'b1);
        rep(2, 1'b1, 4'b0000, L_AR,  1'b1);

        cur_tag = "main_req_only";
        rep(4, 1'b1, 4'b0101, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0101, L_OFF, 1'b0);
        rep(4, 1'b1, 4'b0101, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0101, L_OFF, 1'b0);

        cur_tag = "drop_night";
        cyc(1'b1, 4'b0010, L_ON, 1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b1);
        rep(2, 1'b1, 4'b0000, L_GRN, 1'b1);
        rep(3, 1'b0, 4'b0000, L_SY,  1'b1);
        rep(3, 1'b0, 4'b0000, L_AR,  1'b1);
        rep(2, 1'b1, 4'b0000, L_AR,  1'b1);
        cyc(1'b1, 4'b0000, L_ON, 1'b0);

        cur_tag = "allred_req";
        cyc(1'b1, 4'b1000, L_ON, 1'b0);
        rep(2, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b1);
        rep(5, 1'b1, 4'b0000, L_GRN, 1'b1);
        rep(3, 1'b1, 4'b0000, L_SY,  1'b1);
        cyc(1'b1, 4'b0000, L_AR, 1'b1);
        cyc(1'b1, 4'b0010, L_AR, 1'b1);
        cyc(1'b1, 4'b0000, L_ON, 1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b1);
        cur_tag = "req_in_green";
        cyc(1'b1, 4'b0000, L_GRN, 1'b1);
        rep(4, 1'b1, 4'b0010, L_GRN, 1'b1);
        cyc(1'b1, 4'b0010, L_SY, 1'b1);
        rep(2, 1'b1, 4'b0000, L_SY,  1'b1);
        rep(2, 1'b1, 4'b0000, L_AR,  1'b1);
        rep(4, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0000, L_OFF, 1'b0);
        rep(4, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0000, L_OFF, 1'b0);

        cur_tag = "async_rst";
        cyc(1'b1, 4'b0010, L_ON, 1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(3, 1'b1, 4'b0000, L_ON,  1'b1);
        rep(2, 1'b1, 4'b0000, L_GRN, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (lane_out !== L_ON || serving !== 1'b0) begin
            miss_cnt++;
            $display("FAIL async_rst_immediate: lane_out=%b serving=%b, expected lane_out=%b serving=0",
                     lane_out, serving, L_ON);
        end
        cyc(1'b1, 4'b0000, L_ON, 1'b0);
        rst = 1'b0;
        rep(3, 1'b1, 4'b0000, L_ON,  1'b0);
        rep(4, 1'b1, 4'b0000, L_OFF, 1'b0);

        repeat (3) @(negedge clk);
        vec_cnt++;
        if (sb.size() != 0) begin
            miss_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
